// File: rtl/dsconv_pkg.sv
// Shared types and helpers for the depthwise-separable conv activation stage.
package dsconv_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_CLAMP  = 2'd2,
        ACT_LEAKY  = 2'd3
    } act_mode_t;

    // Saturate a signed value into the range of a signed 'width'-bit number.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                      input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/dsconv_act_lane.sv
// One channel of the activation stage: activation register, then rounding shift,
// saturation and optional clamp into the output register. Both advance on en.
module dsconv_act_lane
    import dsconv_pkg::*;
#(
    parameter int DATA_W      = 18,
    parameter int OUT_W       = 8,
    parameter int SHIFT_W     = 5,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  act_mode_t                 mode,
    input  logic signed [DATA_W-1:0]  x,
    input  logic [SHIFT_W-1:0]        shift_s1,
    input  logic                      clamp_en_s1,
    input  logic [OUT_W-1:0]          clamp_s1,
    output logic signed [OUT_W-1:0]   y
);

    logic signed [DATA_W-1:0] a_d, a_q;
    logic signed [DATA_W:0]   ext, rnd, r;
    logic signed [OUT_W-1:0]  sat, cmax, y_d, y_q;

    always_comb begin
        a_d = x;
        case (mode)
            ACT_BYPASS:          a_d = x;
            ACT_RELU, ACT_CLAMP: a_d = (x > 0) ? x : '0;
            ACT_LEAKY:           a_d = x[DATA_W-1] ? (x >>> LEAKY_SHIFT) : x;
            default:             a_d = x;
        endcase
    end

    // One extra bit of headroom keeps a + 2^(s-1) from overflowing for legal shifts.
    always_comb begin
        ext = {a_q[DATA_W-1], a_q};
        rnd = '0;
        if (shift_s1 != '0) begin
            rnd = (DATA_W + 1)'(1) << (shift_s1 - 1'b1);
        end
        r    = (ext + rnd) >>> shift_s1;
        sat  = OUT_W'(sat_signed(32'(r), OUT_W));
        cmax = clamp_s1[OUT_W-1] ? '0 : clamp_s1;
        y_d  = (clamp_en_s1 && (sat > cmax)) ? cmax : sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            y_q <= '0;
        end else if (en) begin
            a_q <= a_d;
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/dsconv_act_stage.sv
// Multi-lane activation/requantisation stage: two-deep valid/ready pipe with
// per-frame configuration latching and a saturating frame beat counter.
module dsconv_act_stage
    import dsconv_pkg::*;
#(
    parameter int CH          = 4,
    parameter int DATA_W      = 18,
    parameter int OUT_W       = 8,
    parameter int SHIFT_W     = 5,
    parameter int LEAKY_SHIFT = 3,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cfg_mode,
    input  logic [SHIFT_W-1:0]    cfg_shift,
    input  logic [OUT_W-1:0]      cfg_clamp,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*DATA_W-1:0]  in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH*OUT_W-1:0]   out_data,
    output logic                  out_last,
    output logic [CNT_W-1:0]      frame_beats
);

    logic               rdy_d, rdy_q;
    logic               v1_d, v1_q;
    logic               last1_d, last1_q;
    logic               out_valid_d, out_valid_q;
    logic               out_last_d, out_last_q;
    act_mode_t          mode1_d, mode1_q;
    logic [SHIFT_W-1:0] shift1_d, shift1_q;
    logic [OUT_W-1:0]   clamp1_d, clamp1_q;
    act_mode_t          lat_mode_d, lat_mode_q;
    logic [SHIFT_W-1:0] lat_shift_d, lat_shift_q;
    logic [OUT_W-1:0]   lat_clamp_d, lat_clamp_q;
    logic               frame_active_d, frame_active_q;
    logic [CNT_W-1:0]   beats_d, beats_q;

    logic               en, accept;
    act_mode_t          cur_mode;
    logic [SHIFT_W-1:0] cur_shift;
    logic [OUT_W-1:0]   cur_clamp;

    // The first beat of a frame uses the live cfg; later beats use the latched copy.
    always_comb begin
        en        = !out_valid_q || out_ready;
        in_ready  = en && rdy_q;
        accept    = in_valid && in_ready;
        cur_mode  = frame_active_q ? lat_mode_q  : act_mode_t'(cfg_mode);
        cur_shift = frame_active_q ? lat_shift_q : cfg_shift;
        cur_clamp = frame_active_q ? lat_clamp_q : cfg_clamp;
    end

    always_comb begin
        rdy_d          = 1'b1;
        v1_d           = v1_q;
        last1_d        = last1_q;
        mode1_d        = mode1_q;
        shift1_d       = shift1_q;
        clamp1_d       = clamp1_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        lat_mode_d     = lat_mode_q;
        lat_shift_d    = lat_shift_q;
        lat_clamp_d    = lat_clamp_q;
        frame_active_d = frame_active_q;
        beats_d        = beats_q;

        if (en) begin
            v1_d        = accept;
            last1_d     = accept && in_last;
            mode1_d     = cur_mode;
            shift1_d    = cur_shift;
            clamp1_d    = cur_clamp;
            out_valid_d = v1_q;
            out_last_d  = last1_q;
        end

        if (accept) begin
            frame_active_d = !in_last;
            if (!frame_active_q) begin
                lat_mode_d  = act_mode_t'(cfg_mode);
                lat_shift_d = cfg_shift;
                lat_clamp_d = cfg_clamp;
                beats_d     = CNT_W'(1);
            end else if (beats_q != '1) begin
                beats_d = beats_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q          <= 1'b0;
            v1_q           <= 1'b0;
            last1_q        <= 1'b0;
            mode1_q        <= ACT_BYPASS;
            shift1_q       <= '0;
            clamp1_q       <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            lat_mode_q     <= ACT_BYPASS;
            lat_shift_q    <= '0;
            lat_clamp_q    <= '0;
            frame_active_q <= 1'b0;
            beats_q        <= '0;
        end else begin
            rdy_q          <= rdy_d;
            v1_q           <= v1_d;
            last1_q        <= last1_d;
            mode1_q        <= mode1_d;
            shift1_q       <= shift1_d;
            clamp1_q       <= clamp1_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            lat_mode_q     <= lat_mode_d;
            lat_shift_q    <= lat_shift_d;
            lat_clamp_q    <= lat_clamp_d;
            frame_active_q <= frame_active_d;
            beats_q        <= beats_d;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_lane
        dsconv_act_lane #(
            .DATA_W      (DATA_W),
            .OUT_W       (OUT_W),
            .SHIFT_W     (SHIFT_W),
            .LEAKY_SHIFT (LEAKY_SHIFT)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst),
            .en          (en),
            .mode        (cur_mode),
            .x           (in_data[k*DATA_W +: DATA_W]),
            .shift_s1    (shift1_q),
            .clamp_en_s1 (mode1_q == ACT_CLAMP),
            .clamp_s1    (clamp1_q),
            .y           (out_data[k*OUT_W +: OUT_W])
        );
    end

    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign frame_beats = beats_q;

endmodule

// File: tb/tb_dsconv_act_stage.sv
// Directed bench for dsconv_act_stage (2 lanes) with an arithmetic reference model.
module tb_dsconv_act_stage;

    localparam int CH = 2, DW = 18, OW = 8, SW = 5, LS = 3, CW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        cfg_mode = '0;
    logic [SW-1:0]     cfg_shift = '0;
    logic [OW-1:0]     cfg_clamp = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CH*DW-1:0]  in_data = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CH*OW-1:0]  out_data;
    logic              out_last;
    logic [CW-1:0]     frame_beats;

    dsconv_act_stage #(
        .CH(CH), .DATA_W(DW), .OUT_W(OW), .SHIFT_W(SW), .LEAKY_SHIFT(LS), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
        .cfg_clamp(cfg_clamp), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .frame_beats(frame_beats)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int floordiv(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    // Reference: activation, round-half-up division by 2^s, saturate, clamp.
    function automatic int model_lane(input int x, input int mode, input int s, input int clamp);
        int a, r, c;
        case (mode)
            0:       a = x;
            1, 2:    a = (x > 0) ? x : 0;
            default: a = (x >= 0) ? x : floordiv(x, 2 ** LS);
        endcase
        r = (s == 0) ? a : floordiv(a + 2 ** (s - 1), 2 ** s);
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        if (mode == 2) begin
            c = (clamp > 127) ? 0 : clamp;
            if (r > c) r = c;
        end
        return r;
    endfunction

    function automatic int lane_out(input int k);
        logic [CH*OW-1:0] v;
        v = out_data;
        return int'($signed(v[k*OW +: OW]));
    endfunction

    // Scoreboard state
    logic [16:0] exp_q[$];
    bit          m_active;
    int          m_mode, m_shift, m_clamp, m_beats;
    bit          held_v;
    logic [16:0] held;
    bit          rec;
    int          obs[$];

    always @(negedge clk) begin
        logic [16:0] e;
        int x0, x1, y0, y1;
        if (!rst) begin
            exp_q.delete();
            m_active = 1'b0;
            m_beats  = 0;
            held_v   = 1'b0;
        end else begin
            chk("frame_beats", int'(frame_beats), m_beats);
            if (held_v) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'({out_last, out_data}), int'(held));
            end
            held_v = out_valid && !out_ready;
            held   = {out_last, out_data};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL spurious_out: got beat %0h, expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", int'(out_data), int'(e[15:0]));
                    chk("out_last", int'(out_last), int'(e[16]));
                end
                if (rec) obs.push_back(lane_out(0));
            end
            if (in_valid && in_ready) begin
                if (!m_active) begin
                    m_mode  = int'(cfg_mode);
                    m_shift = int'(cfg_shift);
                    m_clamp = int'(cfg_clamp);
                    m_beats = 1;
                end else if (m_beats < 65535) begin
                    m_beats++;
                end
                x0 = int'($signed(in_data[DW-1:0]));
                x1 = int'($signed(in_data[2*DW-1:DW]));
                y0 = model_lane(x0, m_mode, m_shift, m_clamp);
                y1 = model_lane(x1, m_mode, m_shift, m_clamp);
                exp_q.push_back({in_last, 8'(y1), 8'(y0)});
                m_active = !in_last;
            end
        end
    end

    task automatic set_cfg(input int m, input int s, input int c);
        cfg_mode  = 2'(m);
        cfg_shift = SW'(s);
        cfg_clamp = OW'(c);
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input int d0, input int d1, input bit last);
        int n;
        in_valid = 1'b1;
        in_data  = {DW'(d1), DW'(d0)};
        in_last  = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_vec++; n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic one(input string name, input int m, input int s, input int c,
                       input int d0, input int d1, input int e0, input int e1);
        @(posedge clk);
        #1;
        set_cfg(m, s, c);
        send(d0, d1, 1'b1);
        @(negedge clk);
        chk({name, "_lat1_valid"}, int'(out_valid), 0);
        @(negedge clk);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_lane0"}, lane_out(0), e0);
        chk({name, "_lane1"}, lane_out(1), e1);
        chk({name, "_last"}, int'(out_last), 1);
        chk({name, "_beats"}, int'(frame_beats), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Pin the reference model against hand-worked values.
        chk("model_round_neg", model_lane(-7, 0, 2, 0), -2);
        chk("model_leaky", model_lane(-16, 3, 0, 0), -2);
        chk("model_clamp_msb", model_lane(50, 2, 0, 8'h80), 0);

        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_frame_beats", int'(frame_beats), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("in_ready_pre_edge", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("in_ready_post_edge", int'(in_ready), 1);
        out_ready = 1'b1;

        one("relu",        1, 0, 0, -5, 100, 0, 100);
        one("sat_relu",    1, 0, 0, 300, -300, 127, 0);
        one("sat_bypass",  0, 0, 0, 300, -300, 127, -128);
        one("round_pos",   0, 2, 0, 6, 5, 2, 1);
        one("round_neg",   0, 2, 0, -6, -7, -1, -2);
        one("leaky",       3, 0, 0, -16, -1, -2, -1);
        one("clamp",       2, 0, 6, 10, -3, 6, 0);
        one("clamp_msb",   2, 0, 8'h90, 5, 0, 0, 0);

        // Multi-beat frame checked by the model only.
        @(posedge clk);
        #1;
        set_cfg(3, 4, 0);
        send(12345, -54321, 1'b0);
        send(-131072, 131071, 1'b0);
        send(7, -9, 1'b1);
        repeat (4) @(negedge clk);

        // Backpressure with a mid-frame cfg change that must be ignored.
        @(posedge clk);
        #1;
        set_cfg(1, 0, 0);
        rec = 1'b1;
        fork
            begin
                for (int k = 1; k <= 6; k++) begin
                    send(k, 10 * k, k == 6);
                    if (k == 3) set_cfg(3, 3, 0);
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        rec = 1'b0;
        chk("bp_count", obs.size(), 6);
        for (int k = 0; k < 6 && k < obs.size(); k++) chk("bp_order", obs[k], k + 1);
        chk("bp_frame_beats", int'(frame_beats), 6);

        // Reset mid-frame while the output is stalled.
        @(posedge clk);
        #1;
        set_cfg(0, 0, 0);
        out_ready = 1'b0;
        send(1, 2, 1'b0);
        send(3, 4, 1'b0);
        chk("pre_rst_out_valid", int'(out_valid), 1);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_frame_beats", int'(frame_beats), 0);
        chk("midrst_out_data", int'(out_data), 0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        one("newcfg_a", 3, 1, 0, -16, 40, -1, 20);
        one("newcfg_b", 3, 1, 0, -3, 5, 0, 3);

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
